storage_read_client: RTL and testbench
======================================

Name: storage_read_client

Overview:
- Requester-side port for the shared multi-reader storage block.
- Accepts read requests from a pipeline stage (fetch or load unit) over valid/ready.
- Drives one reader lane of the storage (`readAddr`/`readEn`), holds the request until the storage grants it via `readfin`, and captures the same-cycle combinational read data.
- Buffers responses in a small FIFO, so a stalled consumer never loses data and arbitration losses are retried transparently.

Parameters:
- READ_ADDR_SIZE, 28, width of a storage row address.
- ROW_WIDTH, 32, width of one storage row / response data.
- FIFO_DEPTH, 2, response buffer entries; power of two, at least 2.
- STALL_CNT_W, 16, width of the saturating arbitration-loss counter.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset; sampled on clk rising edge, rst=0 resets.
- startSig  in  1  enable; when 0, no new request is accepted.
- reqAddr  in  READ_ADDR_SIZE  requested row address.
- reqValid  in  1  request offered.
- reqReady  out  1  request accepted this cycle when reqValid&reqReady.
- readAddr  out  READ_ADDR_SIZE  address to this client's storage reader lane.
- readEn  out  1  read request to the storage lane.
- readfin  in  1  storage grant; when high with readEn, poolReadData is valid this cycle.
- poolReadData  in  ROW_WIDTH  shared storage read data (combinational).
- respData  out  ROW_WIDTH  returned row (FIFO head).
- respAddr  out  READ_ADDR_SIZE  address of the returned row.
- respValid  out  1  FIFO non-empty.
- respReady  in  1  consumer takes the head when respValid&respReady.
- busy  out  1  pending request or FIFO non-empty.
- stallCnt  out  STALL_CNT_W  cycles with readEn=1 and readfin=0; saturates at all-ones.

Behaviour:
- Reset (rst=0 at posedge): pending=0, readEn=0, readAddr=0, FIFO emptied (respValid=0, respData/respAddr=0), stallCnt=0, busy=0. This applies mid-operation too: an in-flight request is dropped and never retried.
- FSM:
  - IDLE: no pending request.
  - WAIT: pending=1, readEn=1, readAddr=registered address.
- Transitions:
  - IDLE -> WAIT on request accept.
  - WAIT -> IDLE on readfin=1 with no new accept that cycle.
  - WAIT -> WAIT on readfin=1 with a new accept (back-to-back), or on readfin=0 (retry, stallCnt+1).
- readEn and readAddr are registered outputs; readEn=0 in IDLE.
- On readfin=1 while readEn=1: push {poolReadData, readAddr} into the FIFO at that posedge.
- readfin while readEn=0 is ignored.
- occ = FIFO count + pending.
- reqReady = rst & startSig & (!pending | readfin) & (occ < FIFO_DEPTH | (respValid & respReady)).
  - Combinational from readfin/respReady, no dependency on reqValid.
- Latency:
  - Accept at cycle N -> readEn=1 at N+1.
  - Granted at N+1 -> respValid=1 at N+2.
  - No bypass from the storage to respData.
- Throughput: one request per cycle when always granted and respReady=1.
- Full FIFO with simultaneous pop and push: both occur; count unchanged.
- Empty FIFO: pop ignored.
- FIFO wrap: pointers modulo FIFO_DEPTH; order preserved.
- startSig falling while pending: the request still completes and is buffered.
- stallCnt: saturating; no wrap from all-ones.
- busy = pending | respValid.

Decomposition:
- Shared package `storage_pkg`:
  - default READ_ADDR_SIZE/ROW_WIDTH constants.
  - FSM state encoding (IDLE=0, WAIT=1).
  - response entry struct {addr, data}.
- One sub-module `resp_fifo`: synchronous FIFO, parameters WIDTH and DEPTH.
  - Ports: push, pop, din, dout, count, full, empty.
  - Same clk and active-low synchronous rst.

Test Plan:
- Reset: hold rst=0 for 3 cycles with reqValid=1 -> readEn=0, respValid=0, reqReady=0, stallCnt=0; release -> reqReady=1 (startSig=1).
- Single read: mem[0x10]=0xDEADBEEF, readfin tied to readEn, req 0x10 at cycle N -> readEn=1 & readAddr=0x10 at N+1; respValid=1, respData=0xDEADBEEF, respAddr=0x10 at N+2.
- Arbitration loss: readfin forced 0 for 3 cycles then 1 -> readEn held with a stable address for 4 cycles; stallCnt=3; exactly one response.
- Backpressure: respReady=0, issue 4 requests (0x1..0x4) -> only 2 accepted, reqReady=0 after; raise respReady -> responses 0x1, 0x2 then remaining accepted; no loss or reorder.
- Streaming with full FIFO: respReady=1, readfin=1, 8 back-to-back requests 0x20..0x27 -> one response per cycle, in order, reqReady never drops.
- Reset mid-op: rst=0 while pending with 1 FIFO entry -> next cycle readEn=0, respValid=0, busy=0; the dropped address never appears on resp.

Source files
------------

// File: rtl/storage_pkg.sv
// Shared types and defaults for the storage read client slice.
package storage_pkg;

  localparam int unsigned DEF_READ_ADDR_SIZE = 28;
  localparam int unsigned DEF_ROW_WIDTH      = 32;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic [DEF_READ_ADDR_SIZE-1:0] addr;
    logic [DEF_ROW_WIDTH-1:0]      data;
  } resp_entry_t;

endpackage

// File: rtl/storage_read_client_if.sv
// Request, storage-lane and response signals of one storage read client.
interface storage_read_client_if #(
  parameter int unsigned READ_ADDR_SIZE = 28,
  parameter int unsigned ROW_WIDTH      = 32,
  parameter int unsigned STALL_CNT_W    = 16
);

  logic                      startSig;
  logic [READ_ADDR_SIZE-1:0] reqAddr;
  logic                      reqValid;
  logic                      reqReady;
  logic [READ_ADDR_SIZE-1:0] readAddr;
  logic                      readEn;
  logic                      readfin;
  logic [ROW_WIDTH-1:0]      poolReadData;
  logic [ROW_WIDTH-1:0]      respData;
  logic [READ_ADDR_SIZE-1:0] respAddr;
  logic                      respValid;
  logic                      respReady;
  logic                      busy;
  logic [STALL_CNT_W-1:0]    stallCnt;

  // Client side: takes requests, drives the storage lane, returns responses.
  modport slave (
    input  startSig, reqAddr, reqValid, readfin, poolReadData, respReady,
    output reqReady, readAddr, readEn, respData, respAddr, respValid, busy, stallCnt
  );

  // Environment side: pipeline stage plus storage block.
  modport master (
    output startSig, reqAddr, reqValid, readfin, poolReadData, respReady,
    input  reqReady, readAddr, readEn, respData, respAddr, respValid, busy, stallCnt
  );

endinterface

// File: rtl/resp_fifo.sv
// Synchronous response FIFO; simultaneous push and pop allowed when full.
module resp_fifo #(
  parameter  int unsigned WIDTH = 60,
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Pointer, count and storage next-state; pop on empty is dropped.
  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CW'(DEPTH));
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (do_push) begin
      mem_d[wr_q] = din;
      wr_d        = wr_q + PW'(1);
    end
    if (do_pop) begin
      rd_d = rd_q + PW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= '{default: '0};
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Head entry and occupancy.
  always_comb begin
    dout  = mem_q[rd_q];
    count = cnt_q;
  end

endmodule

// File: rtl/storage_read_client.sv
// Requester port for one reader lane of the shared multi-reader storage.
module storage_read_client
  import storage_pkg::*;
#(
  parameter int unsigned READ_ADDR_SIZE = DEF_READ_ADDR_SIZE,
  parameter int unsigned ROW_WIDTH      = DEF_ROW_WIDTH,
  parameter int unsigned FIFO_DEPTH     = 2,
  parameter int unsigned STALL_CNT_W    = 16
) (
  input logic                  clk,
  input logic                  rst,
  storage_read_client_if.slave bus
);

  localparam int unsigned EW = READ_ADDR_SIZE + ROW_WIDTH;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  state_t                    state_q, state_d;
  logic [READ_ADDR_SIZE-1:0] addr_q, addr_d;
  logic [STALL_CNT_W-1:0]    stall_q, stall_d;
  logic                      pending, accept, grant;
  logic                      fifo_pop, fifo_full, fifo_empty;
  logic [CW-1:0]             fifo_count, occ;
  logic [EW-1:0]             fifo_dout;

  // Handshake: the pending slot counts against FIFO space so a granted
  // read always has somewhere to land.
  always_comb begin
    pending      = (state_q == ST_WAIT);
    grant        = pending & bus.readfin;
    fifo_pop     = ~fifo_empty & bus.respReady;
    occ          = fifo_count + CW'(pending);
    bus.reqReady = rst & bus.startSig & (~pending | bus.readfin)
                 & ((occ < DEPTH_C) | fifo_pop);
    accept       = bus.reqValid & bus.reqReady;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next state and captured address.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_WAIT;
          addr_d  = bus.reqAddr;
        end
      end
      ST_WAIT: begin
        if (bus.readfin) begin
          if (accept) addr_d  = bus.reqAddr;
          else        state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Storage lane outputs come straight from registers.
  always_comb begin
    bus.readEn   = pending;
    bus.readAddr = addr_q;
  end

  // Saturating count of lost arbitration cycles.
  always_comb begin
    stall_d = stall_q;
    if (pending && !bus.readfin && (stall_q != '1)) stall_d = stall_q + STALL_CNT_W'(1);
  end

  // Address and stall counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      stall_q <= '0;
    end else begin
      addr_q  <= addr_d;
      stall_q <= stall_d;
    end
  end

  resp_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_resp_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (grant),
    .pop   (fifo_pop),
    .din   ({addr_q, bus.poolReadData}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Response side driven from the FIFO head.
  always_comb begin
    bus.respValid = ~fifo_empty;
    bus.respAddr  = fifo_dout[EW-1:ROW_WIDTH];
    bus.respData  = fifo_dout[ROW_WIDTH-1:0];
    bus.busy      = pending | ~fifo_empty;
    bus.stallCnt  = stall_q;
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    (grant && fifo_full) |-> fifo_pop);

endmodule

// File: tb/tb_storage_read_client.sv
// Randomized bench for storage_read_client with a transaction-level model.
module tb_storage_read_client;
  import storage_pkg::*;

  localparam int unsigned AW   = 28;
  localparam int unsigned DW   = 32;
  localparam int unsigned DEP  = 2;
  localparam int unsigned SW   = 4;
  localparam int unsigned SMAX = 15;

  logic clk;
  logic rst;

  storage_read_client_if #(
    .READ_ADDR_SIZE (AW),
    .ROW_WIDTH      (DW),
    .STALL_CNT_W    (SW)
  ) bus ();

  storage_read_client #(
    .READ_ADDR_SIZE (AW),
    .ROW_WIDTH      (DW),
    .FIFO_DEPTH     (DEP),
    .STALL_CNT_W    (SW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Storage contents: fixed row for 0x10, otherwise derived from the address.
  function automatic logic [DW-1:0] rowf(input logic [AW-1:0] a);
    if (a == 28'h10) return 32'hDEADBEEF;
    return {a[3:0], a} ^ 32'h5A5A_1234;
  endfunction

  assign bus.poolReadData = rowf(bus.readAddr);

  int checks   = 0;
  int failures = 0;
  int n_acc    = 0;

  bit drv_rst, drv_start, drv_valid, drv_readfin, drv_resp_ready;
  logic [AW-1:0] req_src [$];
  logic [AW-1:0] pop_log [$];

  // Reference model state
  resp_entry_t   m_q [$];
  logic          m_pending;
  logic [AW-1:0] m_addr;
  int unsigned   m_stall;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive at negedge, compare against the model, advance the model.
  task automatic step();
    logic        exp_ready, pop, grant, acc;
    int unsigned occ;
    @(negedge clk);
    rst           = drv_rst;
    bus.startSig  = drv_start;
    bus.readfin   = drv_readfin;
    bus.respReady = drv_resp_ready;
    bus.reqValid  = drv_valid && (req_src.size() > 0);
    bus.reqAddr   = (req_src.size() > 0) ? req_src[0] : '0;
    #1;
    occ       = m_q.size() + (m_pending ? 1 : 0);
    pop       = (m_q.size() > 0) && drv_resp_ready;
    exp_ready = drv_rst && drv_start && (!m_pending || drv_readfin) && ((occ < DEP) || pop);
    check_eq("reqReady", 64'(bus.reqReady), 64'(exp_ready));
    check_eq("readEn", 64'(bus.readEn), 64'(m_pending));
    if (m_pending) check_eq("readAddr", 64'(bus.readAddr), 64'(m_addr));
    check_eq("respValid", 64'(bus.respValid), 64'(m_q.size() > 0));
    if (m_q.size() > 0) begin
      check_eq("respAddr", 64'(bus.respAddr), 64'(m_q[0].addr));
      check_eq("respData", 64'(bus.respData), 64'(m_q[0].data));
    end
    check_eq("busy", 64'(bus.busy), 64'(m_pending || (m_q.size() > 0)));
    check_eq("stallCnt", 64'(bus.stallCnt), 64'(m_stall));
    acc   = bus.reqValid && exp_ready;
    grant = m_pending && drv_readfin;
    if (!drv_rst) begin
      m_q.delete();
      m_pending = 1'b0;
      m_addr    = '0;
      m_stall   = 0;
    end else begin
      if (pop) begin
        pop_log.push_back(m_q[0].addr);
        void'(m_q.pop_front());
      end
      if (grant) m_q.push_back('{addr: m_addr, data: rowf(m_addr)});
      if (m_pending && !drv_readfin && (m_stall < SMAX)) m_stall++;
      if (acc) begin
        m_addr = req_src.pop_front();
        n_acc++;
      end
      m_pending = acc || (m_pending && !drv_readfin);
    end
    @(posedge clk);
  endtask

  task automatic check_log(input string tag, input logic [AW-1:0] base, input int n);
    logic [AW-1:0] got;
    check_eq({tag, "_count"}, 64'(pop_log.size()), 64'(n));
    for (int i = 0; i < n; i++) begin
      got = (i < int'(pop_log.size())) ? pop_log[i] : '1;
      check_eq(tag, 64'(got), 64'(base + AW'(i)));
    end
  endtask

  task automatic idle_drain(input int n);
    drv_rst = 1; drv_valid = 0; drv_readfin = 1; drv_resp_ready = 1;
    repeat (n) step();
  endtask

  initial begin
    int n0, n55;
    m_pending = 0; m_addr = '0; m_stall = 0;
    // Reset held with a request offered
    rst = 0; bus.startSig = 1; bus.reqValid = 1; bus.reqAddr = 28'h10;
    bus.readfin = 1; bus.respReady = 1;
    repeat (2) @(posedge clk);
    drv_rst = 0; drv_start = 1; drv_valid = 1; drv_readfin = 1; drv_resp_ready = 1;
    req_src.push_back(28'h33);
    repeat (3) step();
    #1;
    check_eq("rst_readEn", 64'(bus.readEn), 64'd0);
    check_eq("rst_respValid", 64'(bus.respValid), 64'd0);
    check_eq("rst_respData", 64'(bus.respData), 64'd0);
    check_eq("rst_readAddr", 64'(bus.readAddr), 64'd0);
    req_src.delete();
    drv_rst = 1;
    step();

    // Single read
    req_src.push_back(28'h10);
    step();
    #1;
    check_eq("single_readEn", 64'(bus.readEn), 64'd1);
    check_eq("single_readAddr", 64'(bus.readAddr), 64'h10);
    step();
    #1;
    check_eq("single_respValid", 64'(bus.respValid), 64'd1);
    check_eq("single_respData", 64'(bus.respData), 64'hDEADBEEF);
    check_eq("single_respAddr", 64'(bus.respAddr), 64'h10);
    idle_drain(2);

    // Arbitration loss
    pop_log.delete();
    req_src.push_back(28'hA0);
    drv_valid = 1; drv_readfin = 0;
    repeat (4) step();
    drv_readfin = 1;
    step();
    #1;
    check_eq("arb_stallCnt", 64'(bus.stallCnt), 64'd3);
    check_eq("arb_respAddr", 64'(bus.respAddr), 64'hA0);
    idle_drain(3);
    check_log("arb_resp", 28'hA0, 1);

    // Backpressure
    pop_log.delete();
    n0 = n_acc;
    for (int i = 1; i <= 4; i++) req_src.push_back(AW'(i));
    drv_valid = 1; drv_readfin = 1; drv_resp_ready = 0;
    repeat (6) step();
    check_eq("bp_accepted", 64'(n_acc - n0), 64'd2);
    drv_resp_ready = 1;
    repeat (10) step();
    check_eq("bp_src_empty", 64'(req_src.size()), 64'd0);
    check_log("bp_order", 28'h1, 4);

    // Streaming back-to-back
    pop_log.delete();
    n0 = n_acc;
    for (int i = 0; i < 8; i++) req_src.push_back(28'h20 + AW'(i));
    drv_valid = 1; drv_readfin = 1; drv_resp_ready = 1;
    repeat (8) step();
    check_eq("stream_accepted", 64'(n_acc - n0), 64'd8);
    repeat (4) step();
    check_log("stream_order", 28'h20, 8);

    // Stall counter saturation
    req_src.push_back(28'h77);
    drv_valid = 1; drv_readfin = 0;
    repeat (20) step();
    #1;
    check_eq("stall_sat", 64'(bus.stallCnt), 64'(SMAX));
    idle_drain(3);

    // Reset mid-operation drops the in-flight request
    pop_log.delete();
    req_src.push_back(28'h50);
    req_src.push_back(28'h55);
    drv_valid = 1; drv_readfin = 1; drv_resp_ready = 0;
    repeat (2) step();
    drv_readfin = 0; drv_rst = 0;
    step();
    #1;
    check_eq("midrst_readEn", 64'(bus.readEn), 64'd0);
    check_eq("midrst_respValid", 64'(bus.respValid), 64'd0);
    check_eq("midrst_busy", 64'(bus.busy), 64'd0);
    idle_drain(5);
    n55 = 0;
    foreach (pop_log[i]) if (pop_log[i] == 28'h55) n55++;
    check_eq("midrst_dropped", 64'(n55), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if (req_src.size() < 4) req_src.push_back(AW'($urandom));
      drv_rst        = ($urandom_range(99) != 0);
      drv_start      = ($urandom_range(9) != 0);
      drv_valid      = ($urandom_range(9) < 7);
      drv_readfin    = ($urandom_range(9) < 6);
      drv_resp_ready = ($urandom_range(9) < 6);
      step();
    end
    req_src.delete();
    idle_drain(6);
    check_eq("final_busy", 64'(bus.busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
